// File: rtl/cpu_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : cpu_memory_responder
// Description : Memory-side responder for the CPU memory interface. Serves
//               CPU reads (c_ro) and writes (c_ri) on the shared 8-bit bus.
//               The address map is:
//                 0x00 .. IO_BASE-1 : RAM, asynchronous read
//                 IO_BASE           : input status {7'b0, in_valid}
//                 IO_BASE+1         : write pushes the output FIFO,
//                                     read returns {overflow, 0, count}
//                 IO_BASE+2         : input data byte, pops the upstream
//                                     producer when read
//               A program-load port fills RAM while the CPU is held in reset.
//
// Ports       : clk        system clock, shared with the CPU
//               reset      asynchronous, active-low reset
//               addr_bus   CPU memory address (MAR)
//               c_ri       CPU write strobe (memory takes the bus)
//               c_ro       CPU read strobe (memory drives the bus)
//               mem_clk    CPU memory phase, qualifies strobes
//               bus        shared CPU data bus (inout)
//               load_en    program-load mode, masks the CPU strobes
//               load_we    load write enable
//               load_addr  load address
//               load_data  load data
//               out_data   head of the output FIFO
//               out_valid  output FIFO non-empty
//               out_ready  downstream accepts out_data
//               in_data    upstream input byte
//               in_valid   upstream byte available
//               in_ready   one-clk pop pulse to upstream
//               overflow   sticky flag: a push to a full FIFO was dropped
//
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_memory_responder #(
    parameter int         FIFO_AW = 2,
    parameter logic [7:0] IO_BASE = 8'hFD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] addr_bus,
    input  logic       c_ri,
    input  logic       c_ro,
    input  logic       mem_clk,
    inout  wire  [7:0] bus,
    input  logic       load_en,
    input  logic       load_we,
    input  logic [7:0] load_addr,
    input  logic [7:0] load_data,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       overflow
);

    localparam int               c_fifo_depth   = 1 << FIFO_AW;
    localparam int               c_ram_depth    = int'(IO_BASE);
    localparam logic [7:0]       c_addr_in_stat = IO_BASE;
    localparam logic [7:0]       c_addr_out     = IO_BASE + 8'd1;
    localparam logic [7:0]       c_addr_in_data = IO_BASE + 8'd2;
    localparam logic [FIFO_AW:0] c_fifo_full    = {1'b1, {FIFO_AW{1'b0}}};

    // ------------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------------
    logic [7:0]       r_ram  [0:c_ram_depth-1];
    logic [7:0]       r_fifo [0:c_fifo_depth-1];
    logic [FIFO_AW:0] r_wr_ptr;
    logic [FIFO_AW:0] r_rd_ptr;
    logic             r_overflow;
    logic             r_in_ready;

    // ------------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------------
    logic             w_mem_event;
    logic             w_is_ram;
    logic             w_cpu_rd;
    logic             w_cpu_wr;
    logic             w_ram_we_cpu;
    logic             w_ram_we_load;
    logic [FIFO_AW:0] w_count;
    logic             w_out_valid;
    logic             w_full;
    logic             w_pop;
    logic             w_push_req;
    logic             w_push;
    logic [7:0]       w_status;
    logic [7:0]       w_rd_data;

    assign w_mem_event   = mem_clk & ~load_en;
    assign w_is_ram      = (addr_bus < IO_BASE);
    assign w_cpu_rd      = c_ro & ~load_en;
    // A simultaneous read strobe takes priority, so no write happens then.
    assign w_cpu_wr      = w_mem_event & c_ri & ~c_ro;
    assign w_ram_we_cpu  = w_cpu_wr & w_is_ram;
    assign w_ram_we_load = load_en & load_we & (load_addr < IO_BASE);

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign w_count     = r_wr_ptr - r_rd_ptr;
    assign w_out_valid = (w_count != '0);
    assign w_full      = (w_count == c_fifo_full);
    assign w_pop       = w_out_valid & out_ready;
    assign w_push_req  = w_cpu_wr & (addr_bus == c_addr_out);
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_push      = w_push_req & (~w_full | w_pop);
    assign w_status    = {r_overflow, 7'(w_count)};

    // ------------------------------------------------------------------------
    // Read data mux and bus driver
    // ------------------------------------------------------------------------
    always_comb begin
        w_rd_data = 8'h00;
        if (w_is_ram) begin
            w_rd_data = r_ram[addr_bus];
        end else if (addr_bus == c_addr_in_stat) begin
            w_rd_data = {7'b0, in_valid};
        end else if (addr_bus == c_addr_out) begin
            w_rd_data = w_status;
        end else if (addr_bus == c_addr_in_data) begin
            w_rd_data = in_valid ? in_data : 8'h00;
        end
    end

    // Reset gates the driver directly so the bus is released the moment
    // reset asserts, even in the middle of a read.
    assign bus = (reset && w_cpu_rd) ? w_rd_data : 8'hzz;

    // ------------------------------------------------------------------------
    // RAM (contents survive reset)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_ram_we_load) begin
            r_ram[load_addr] <= load_data;
        end else if (w_ram_we_cpu) begin
            r_ram[addr_bus] <= bus;
        end
    end

    // ------------------------------------------------------------------------
    // Output FIFO storage
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr[FIFO_AW-1:0]] <= bus;
        end
    end

    // ------------------------------------------------------------------------
    // Pointers, sticky overflow and input pop pulse
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
            r_in_ready <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push_req && !w_push) begin
                r_overflow <= 1'b1;
            end
            // mem_clk is high for a single clk, so this is a one-clk pulse.
            r_in_ready <= w_mem_event & c_ro & in_valid &
                          (addr_bus == c_addr_in_data);
        end
    end

    assign out_data  = r_fifo[r_rd_ptr[FIFO_AW-1:0]];
    assign out_valid = w_out_valid;
    assign overflow  = r_overflow;
    assign in_ready  = r_in_ready;

endmodule
`default_nettype wire

// File: tb/tb_cpu_memory_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_memory_responder
// Description : Self-checking bench for cpu_memory_responder. Bytes pushed
//               to the output port are queued as expected values and popped
//               when the responder hands them downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_memory_responder;

    localparam logic [7:0] c_released = 8'hFF;  // pulled-up idle bus
    localparam logic [7:0] c_out_addr = 8'hFE;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] addr_bus;
    logic       c_ri;
    logic       c_ro;
    logic       mem_clk;
    wire  [7:0] bus;
    logic       load_en;
    logic       load_we;
    logic [7:0] load_addr;
    logic [7:0] load_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       overflow;

    logic       tb_drv;
    logic [7:0] tb_data;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] q_exp[$];
    logic       m_ovf;

    assign bus = tb_drv ? tb_data : 8'hzz;

    for (genvar gi = 0; gi < 8; gi++) begin : g_pull
        pullup pu (bus[gi]);
    end

    always #5 clk = ~clk;

    cpu_memory_responder dut (
        .clk       (clk),
        .reset     (reset),
        .addr_bus  (addr_bus),
        .c_ri      (c_ri),
        .c_ro      (c_ro),
        .mem_clk   (mem_clk),
        .bus       (bus),
        .load_en   (load_en),
        .load_we   (load_we),
        .load_addr (load_addr),
        .load_data (load_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [7:0] m_status();
        return {m_ovf, 4'b0000, 3'(q_exp.size())};
    endfunction

    // Downstream monitor: a pop happens at the next posedge whenever
    // out_valid and out_ready are both high.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset && out_valid && out_ready) begin
                if (q_exp.size() != 0) check("fifo_out", out_data, q_exp.pop_front());
                else check("fifo_unexp_valid", {7'b0, out_valid}, 8'h00);
            end
        end
    end

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d,
                             input logic ev, input logic pop_once);
        @(negedge clk);
        addr_bus = a;
        c_ri     = 1'b1;
        tb_drv   = 1'b1;
        tb_data  = d;
        mem_clk  = ev;
        if (pop_once) out_ready = 1'b1;
        #3;
        // The monitor has already retired any same-edge pop at this point.
        if (ev && a == c_out_addr) begin
            if (q_exp.size() < 4) q_exp.push_back(d);
            else m_ovf = 1'b1;
        end
        @(negedge clk);
        c_ri    = 1'b0;
        tb_drv  = 1'b0;
        mem_clk = 1'b0;
        if (pop_once) out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic cpu_read(input logic [7:0] a, input logic [7:0] exp,
                            input logic exp_pulse, input string tag);
        @(negedge clk);
        addr_bus = a;
        c_ro     = 1'b1;
        mem_clk  = 1'b1;
        #3 check({tag, "_data"}, bus, exp);
        @(negedge clk);
        c_ro    = 1'b0;
        mem_clk = 1'b0;
        #3 check({tag, "_pulse"}, {7'b0, in_ready}, {7'b0, exp_pulse});
        check({tag, "_rel"}, bus, c_released);
        @(negedge clk);
        #3 check({tag, "_pulse_end"}, {7'b0, in_ready}, 8'h00);
    endtask

    task automatic drain(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        repeat (8) @(negedge clk);
        #3 check({tag, "_empty"}, {7'b0, out_valid}, {7'b0, (q_exp.size() != 0)});
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b0;
        addr_bus  = 8'h00;
        c_ri      = 1'b0;
        c_ro      = 1'b0;
        mem_clk   = 1'b0;
        load_en   = 1'b0;
        load_we   = 1'b0;
        load_addr = 8'h00;
        load_data = 8'h00;
        out_ready = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        tb_drv    = 1'b0;
        tb_data   = 8'h00;
        m_ovf     = 1'b0;

        // Reset state
        #3;
        check("rst_out_valid", {7'b0, out_valid}, 8'h00);
        check("rst_overflow", {7'b0, overflow}, 8'h00);
        check("rst_in_ready", {7'b0, in_ready}, 8'h00);
        check("rst_bus", bus, c_released);
        @(negedge clk);
        reset = 1'b1;

        // Program load, including an ignored I/O address and a masked read
        @(negedge clk);
        load_en = 1'b1; load_we = 1'b1; load_addr = 8'h10; load_data = 8'hAB;
        @(negedge clk);
        load_addr = 8'h21; load_data = 8'h11;
        @(negedge clk);
        load_addr = c_out_addr; load_data = 8'h99;
        addr_bus = 8'h10; c_ro = 1'b1;
        #3 check("load_bus_rel", bus, c_released);
        @(negedge clk);
        load_en = 1'b0; load_we = 1'b0; c_ro = 1'b0;
        #3 check("load_fifo_empty", {7'b0, out_valid}, 8'h00);

        cpu_read(8'h10, 8'hAB, 1'b0, "ram_load");

        // CPU RAM writes with and without a memory event
        cpu_write(8'h20, 8'h5C, 1'b1, 1'b0);
        cpu_read(8'h20, 8'h5C, 1'b0, "ram_wr");
        cpu_write(8'h21, 8'h5C, 1'b0, 1'b0);
        cpu_read(8'h21, 8'h11, 1'b0, "ram_nomem");

        // Full FIFO with a same-edge pop: no overflow, count stays 4
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) cpu_write(c_out_addr, 8'hA1 + 8'(i), 1'b1, 1'b0);
        cpu_read(c_out_addr, m_status(), 1'b0, "full_stat");
        #1 check("full_head", out_data, q_exp[0]);
        cpu_write(c_out_addr, 8'h77, 1'b1, 1'b1);
        cpu_read(c_out_addr, m_status(), 1'b0, "fullpop_stat");
        check("fullpop_ovf", {7'b0, overflow}, {7'b0, m_ovf});
        drain("fullpop_drain");

        // Overflow: five pushes into a stalled FIFO
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) cpu_write(c_out_addr, 8'(i), 1'b1, 1'b0);
        cpu_read(c_out_addr, m_status(), 1'b0, "ovf_stat");
        #1 check("ovf_head", out_data, 8'h01);
        check("ovf_flag", {7'b0, overflow}, 8'h01);
        drain("ovf_drain");

        // Input handshake port
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h3C;
        cpu_read(8'hFD, 8'h01, 1'b0, "in_stat_v");
        cpu_read(8'hFF, 8'h3C, 1'b1, "in_data_v");
        @(negedge clk);
        in_valid = 1'b0;
        cpu_read(8'hFF, 8'h00, 1'b0, "in_data_nv");
        cpu_read(8'hFD, 8'h00, 1'b0, "in_stat_nv");

        // Reset in the middle of a read with two bytes queued
        @(negedge clk);
        out_ready = 1'b0;
        cpu_write(c_out_addr, 8'h11, 1'b1, 1'b0);
        cpu_write(c_out_addr, 8'h22, 1'b1, 1'b0);
        cpu_read(c_out_addr, m_status(), 1'b0, "pre_rst_stat");
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h3C;
        addr_bus = 8'hFF; c_ro = 1'b1; mem_clk = 1'b1;
        #3 check("midrst_bus_before", bus, 8'h3C);
        @(posedge clk);
        #1 check("midrst_pulse", {7'b0, in_ready}, 8'h01);
        #1 reset = 1'b0;
        #1;
        check("midrst_pulse_cancel", {7'b0, in_ready}, 8'h00);
        check("midrst_bus", bus, c_released);
        check("midrst_out_valid", {7'b0, out_valid}, 8'h00);
        check("midrst_overflow", {7'b0, overflow}, 8'h00);
        q_exp.delete();
        m_ovf = 1'b0;
        @(negedge clk);
        c_ro = 1'b0; mem_clk = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        cpu_read(c_out_addr, 8'h00, 1'b0, "post_rst_stat");
        cpu_read(8'h10, 8'hAB, 1'b0, "post_rst_ram");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
